// File: rtl/menu_display.sv
// Stacked-button start menu: tracks the highlighted entry, blinks it through a
// confirm phase, fires a one-cycle start pulse and renders the menu pixel stream.
`timescale 1ns/1ps
module menu_display #(
    parameter int          NUM_BUTTONS  = 3,
    parameter int          BTN_X        = 380,
    parameter int          BTN_Y0       = 300,
    parameter int          BTN_SPACING  = 120,
    parameter int          BTN_WIDTH    = 200,
    parameter int          BTN_HEIGHT   = 100,
    parameter logic [23:0] BASE_COLOR   = 24'h80_80_80,
    parameter logic [23:0] HILITE_COLOR = 24'hF4_63_05,
    parameter int          ARROW_STEPS  = 4,
    parameter int          ARROW_H      = 60,
    parameter logic [23:0] ARROW_COLOR  = 24'hFF_FF_FF,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        new_frame_in,
    input  logic        up_in,
    input  logic        down_in,
    input  logic        select_in,
    input  logic [23:0] img_sprite_in,
    output logic [23:0] display_out,
    output logic [1:0]  sel_idx_out,
    output logic        start_out,
    output logic        busy_out
);

    localparam int              FC_W     = $clog2(BLINK_FRAMES);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [1:0]      SEL_LAST = 2'(NUM_BUTTONS - 1);

    typedef enum logic [1:0] {BROWSE, CONFIRM, FIRE} state_t;

    state_t          state;
    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;

    // Staircase arrow geometry: column k is 10 px wide, heights shrink left to right.
    function automatic logic [11:0] col_x0(input int k);
        return 12'(BTN_X + BTN_WIDTH / 2 - 20 + 10 * k);
    endfunction

    function automatic logic [11:0] col_h(input int k);
        return 12'(ARROW_H - k * ARROW_H / ARROW_STEPS);
    endfunction

    function automatic logic [11:0] col_yoff(input int k);
        return 12'((BTN_HEIGHT - (ARROW_H - k * ARROW_H / ARROW_STEPS)) / 2);
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= BROWSE;
            sel_idx_out <= 2'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            start_out   <= 1'b0;
        end else begin
            start_out <= 1'b0;
            case (state)
                BROWSE: begin
                    if (select_in) begin
                        state       <= CONFIRM;
                        frame_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end else if (up_in && !down_in) begin
                        sel_idx_out <= (sel_idx_out == 2'd0) ? SEL_LAST : sel_idx_out - 2'd1;
                    end else if (down_in && !up_in) begin
                        sel_idx_out <= (sel_idx_out == SEL_LAST) ? 2'd0 : sel_idx_out + 2'd1;
                    end
                end
                CONFIRM: begin
                    if (new_frame_in) begin
                        if (frame_cnt == FC_LAST) begin
                            state     <= FIRE;
                            start_out <= 1'b1;
                        end else begin
                            frame_cnt   <= frame_cnt + FC_W'(1);
                            blink_phase <= ~blink_phase;
                        end
                    end
                end
                FIRE: begin
                    state       <= BROWSE;
                    frame_cnt   <= '0;
                    blink_phase <= 1'b0;
                end
                default: state <= BROWSE;
            endcase
        end
    end

    assign busy_out = (state == CONFIRM) || (state == FIRE);

    logic [11:0] hx, vy, sel_top;
    logic [3:0]  in_btn;
    logic        arrow_hit;
    logic        blank;
    logic [23:0] pix_next;

    assign hx      = {1'b0, hcount_in};
    assign vy      = {2'b0, vcount_in};
    assign sel_top = 12'(BTN_Y0) + 12'(sel_idx_out) * 12'(BTN_SPACING);
    assign blank   = (state == CONFIRM) && blink_phase;

    always_comb begin
        in_btn = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i < NUM_BUTTONS) begin
                in_btn[i] = (hx >= 12'(BTN_X)) && (hx < 12'(BTN_X + BTN_WIDTH)) &&
                            (vy >= 12'(BTN_Y0 + i * BTN_SPACING)) &&
                            (vy < 12'(BTN_Y0 + i * BTN_SPACING + BTN_HEIGHT));
            end
        end

        arrow_hit = 1'b0;
        for (int k = 0; k < ARROW_STEPS; k++) begin
            if ((hx >= col_x0(k)) && (hx < col_x0(k) + 12'd10) &&
                (vy >= sel_top + col_yoff(k)) &&
                (vy < sel_top + col_yoff(k) + col_h(k))) begin
                arrow_hit = 1'b1;
            end
        end
        arrow_hit = arrow_hit && in_btn[sel_idx_out];

        if (img_sprite_in != 24'd0) begin
            pix_next = img_sprite_in;
        end else if (arrow_hit) begin
            pix_next = blank ? 24'd0 : ARROW_COLOR;
        end else if (in_btn[sel_idx_out]) begin
            pix_next = blank ? 24'd0 : HILITE_COLOR;
        end else if (in_btn != 4'b0000) begin
            pix_next = BASE_COLOR;
        end else begin
            pix_next = 24'd0;
        end
    end

    // Output stage: one register between the pixel coordinates and display_out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            display_out <= 24'd0;
        end else begin
            display_out <= pix_next;
        end
    end

endmodule

// File: tb/tb_menu_display.sv
// Directed self-checking bench for menu_display with default parameters.
`timescale 1ns/1ps
module tb_menu_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        new_frame, up, down, select;
    logic [23:0] sprite;
    logic [23:0] display;
    logic [1:0]  sel_idx;
    logic        start, busy;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] HILI  = 24'hF46305;
    localparam logic [23:0] BASE  = 24'h808080;

    menu_display dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .new_frame_in  (new_frame),
        .up_in         (up),
        .down_in       (down),
        .select_in     (select),
        .img_sprite_in (sprite),
        .display_out   (display),
        .sel_idx_out   (sel_idx),
        .start_out     (start),
        .busy_out      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic u, input logic d, input logic s, input logic f);
        up = u; down = d; select = s; new_frame = f;
        tick();
        up = 1'b0; down = 1'b0; select = 1'b0; new_frame = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        up = 1'b0; down = 1'b0; select = 1'b0; new_frame = 1'b0;
        hcount = 11'd470; vcount = 10'd330; sprite = 24'd0;
        repeat (3) tick();
        n_checks++; if (display !== 24'd0) $display("FAIL reset_display: got %h expected %h", display, 24'd0); else n_pass++;
        n_checks++; if (sel_idx !== 2'd0) $display("FAIL reset_sel: got %0d expected 0", sel_idx); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL reset_start: got %b expected 0", start); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pixels();
        logic [10:0] hv [15] = '{11'd470, 11'd390, 11'd390, 11'd470, 11'd10, 11'd579, 11'd580,
                                 11'd390, 11'd390, 11'd460, 11'd460, 11'd499, 11'd499, 11'd500, 11'd470};
        logic [9:0]  vv [15] = '{10'd330, 10'd330, 10'd450, 10'd330, 10'd10, 10'd300, 10'd300,
                                 10'd399, 10'd400, 10'd320, 10'd319, 10'd342, 10'd357, 10'd342, 10'd450};
        logic [23:0] sv [15] = '{24'd0, 24'd0, 24'd0, 24'h000001, 24'd0, 24'd0, 24'd0,
                                 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
        logic [23:0] ev [15] = '{WHITE, HILI, BASE, 24'h000001, 24'd0, HILI, 24'd0,
                                 HILI, 24'd0, WHITE, HILI, WHITE, HILI, HILI, BASE};
        for (int i = 0; i < 15; i++) begin
            hcount = hv[i]; vcount = vv[i]; sprite = sv[i];
            tick();
            n_checks++;
            if (display !== ev[i]) $display("FAIL pixel_%0d (h=%0d v=%0d): got %h expected %h", i, hv[i], vv[i], display, ev[i]);
            else n_pass++;
        end
        hcount = 11'd10; vcount = 10'd10; sprite = 24'd0;
        #2;
        n_checks++; if (display !== BASE) $display("FAIL latency_hold: got %h expected %h", display, BASE); else n_pass++;
        tick();
        n_checks++; if (display !== 24'd0) $display("FAIL latency_update: got %h expected %h", display, 24'd0); else n_pass++;
    endtask

    task automatic test_navigation();
        logic [1:0] exp_seq [3] = '{2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++; if (sel_idx !== exp_seq[i]) $display("FAIL nav_up_%0d: got %0d expected %0d", i, sel_idx, exp_seq[i]); else n_pass++;
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (sel_idx !== 2'd2) $display("FAIL nav_up_wrap: got %0d expected 2", sel_idx); else n_pass++;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (sel_idx !== 2'd0) $display("FAIL nav_down_wrap: got %0d expected 0", sel_idx); else n_pass++;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (sel_idx !== 2'd0) $display("FAIL nav_up_down: got %0d expected 0", sel_idx); else n_pass++;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (sel_idx !== 2'd1) $display("FAIL nav_down: got %0d expected 1", sel_idx); else n_pass++;
        hcount = 11'd470; vcount = 10'd450;
        tick();
        n_checks++; if (display !== WHITE) $display("FAIL nav_arrow_follows: got %h expected %h", display, WHITE); else n_pass++;
        hcount = 11'd470; vcount = 10'd330;
        tick();
        n_checks++; if (display !== HILI && display !== BASE) $display("FAIL nav_old_arrow: got %h expected %h", display, BASE);
        else if (display !== BASE) $display("FAIL nav_old_arrow: got %h expected %h", display, BASE); else n_pass++;
    endtask

    task automatic test_confirm();
        hcount = 11'd390; vcount = 10'd450; sprite = 24'd0;
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++; if (sel_idx !== 2'd1) $display("FAIL confirm_sel_priority: got %0d expected 1", sel_idx); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL confirm_busy: got %b expected 1", busy); else n_pass++;
        tick();
        n_checks++; if (display !== HILI) $display("FAIL confirm_phase0: got %h expected %h", display, HILI); else n_pass++;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (sel_idx !== 2'd1) $display("FAIL confirm_ignore_up: got %0d expected 1", sel_idx); else n_pass++;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (busy !== 1'b1) $display("FAIL confirm_ignore_select: got %b expected 1", busy); else n_pass++;
        for (int f = 1; f <= 30; f++) begin
            pulse(1'b0, 1'b0, 1'b0, 1'b1);
            if (f < 30) begin
                n_checks++; if (start !== 1'b0) $display("FAIL confirm_early_start_f%0d: got %b expected 0", f, start); else n_pass++;
                n_checks++; if (busy !== 1'b1) $display("FAIL confirm_busy_f%0d: got %b expected 1", f, busy); else n_pass++;
                tick();
                n_checks++;
                if (display !== ((f % 2 == 1) ? 24'd0 : HILI))
                    $display("FAIL confirm_blink_f%0d: got %h expected %h", f, display, (f % 2 == 1) ? 24'd0 : HILI);
                else n_pass++;
            end else begin
                n_checks++; if (start !== 1'b1) $display("FAIL fire_start: got %b expected 1", start); else n_pass++;
                n_checks++; if (busy !== 1'b1) $display("FAIL fire_busy: got %b expected 1", busy); else n_pass++;
            end
        end
        tick();
        n_checks++; if (start !== 1'b0) $display("FAIL fire_single_pulse: got %b expected 0", start); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL fire_done_busy: got %b expected 0", busy); else n_pass++;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (sel_idx !== 2'd0) $display("FAIL browse_resumes: got %0d expected 0", sel_idx); else n_pass++;
    endtask

    task automatic test_reset_abort();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        hcount = 11'd390; vcount = 10'd560;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 10; f++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++; if (display !== HILI) $display("FAIL abort_pre_display: got %h expected %h", display, HILI); else n_pass++;
        n_checks++; if (sel_idx !== 2'd2) $display("FAIL abort_pre_sel: got %0d expected 2", sel_idx); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (display !== 24'd0) $display("FAIL abort_async_display: got %h expected 0", display); else n_pass++;
        n_checks++; if (sel_idx !== 2'd0) $display("FAIL abort_async_sel: got %0d expected 0", sel_idx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_async_busy: got %b expected 0", busy); else n_pass++;
        for (int f = 0; f < 3; f++) begin
            pulse(1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++; if (start !== 1'b0) $display("FAIL abort_no_start_%0d: got %b expected 0", f, start); else n_pass++;
        end
        rst_n = 1'b1;
        hcount = 11'd390; vcount = 10'd330;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (busy !== 1'b1) $display("FAIL restart_busy: got %b expected 1", busy); else n_pass++;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++; if (display !== 24'd0) $display("FAIL restart_blank_f1: got %h expected 0", display); else n_pass++;
        for (int f = 2; f <= 29; f++) begin
            pulse(1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++; if (start !== 1'b0) $display("FAIL restart_early_start_f%0d: got %b expected 0", f, start); else n_pass++;
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (start !== 1'b1) $display("FAIL restart_fire: got %b expected 1", start); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL restart_done_busy: got %b expected 0", busy); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_pixels();
        test_navigation();
        test_confirm();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
